// File: rtl/system_command_controller_if.sv
// Bus bundle between the command controller and its neighbours: UART receive/transmit,
// register file and ALU. The controller uses the master modport.
interface system_command_controller_if #(
    parameter int DATA_WIDTH         = 8,
    parameter int ADDRESS_WIDTH      = 4,
    parameter int ALU_FUNCTION_WIDTH = 4
);
    logic [DATA_WIDTH-1:0]         rx_data;
    logic                          rx_data_valid;
    logic [ADDRESS_WIDTH-1:0]      register_file_address;
    logic                          register_file_write_enable;
    logic [DATA_WIDTH-1:0]         register_file_write_data;
    logic                          register_file_read_enable;
    logic [DATA_WIDTH-1:0]         register_file_read_data;
    logic                          register_file_read_data_valid;
    logic                          ALU_enable;
    logic [ALU_FUNCTION_WIDTH-1:0] ALU_function;
    logic [2*DATA_WIDTH-1:0]       ALU_result;
    logic                          ALU_result_valid;
    logic [DATA_WIDTH-1:0]         tx_data;
    logic                          tx_data_valid;
    logic                          transmitter_busy;
    logic                          command_error;

    modport master (
        input  rx_data, rx_data_valid,
        input  register_file_read_data, register_file_read_data_valid,
        input  ALU_result, ALU_result_valid, transmitter_busy,
        output register_file_address, register_file_write_enable, register_file_write_data,
        output register_file_read_enable, ALU_enable, ALU_function,
        output tx_data, tx_data_valid, command_error
    );

    modport slave (
        output rx_data, rx_data_valid,
        output register_file_read_data, register_file_read_data_valid,
        output ALU_result, ALU_result_valid, transmitter_busy,
        input  register_file_address, register_file_write_enable, register_file_write_data,
        input  register_file_read_enable, ALU_enable, ALU_function,
        input  tx_data, tx_data_valid, command_error
    );
endinterface

// File: rtl/system_command_controller.sv
// Command frame sequencer: decodes UART command bytes into register file / ALU operations and
// queues response bytes in a small FIFO that drains one byte per transmitter busy cycle.
module system_command_controller #(
    parameter int DATA_WIDTH          = 8,
    parameter int ADDRESS_WIDTH       = 4,
    parameter int ALU_FUNCTION_WIDTH  = 4,
    parameter int RESPONSE_FIFO_DEPTH = 4
) (
    input  logic                         reference_clk,
    input  logic                         reset,
    system_command_controller_if.master  bus
);
    localparam int FAW = $clog2(RESPONSE_FIFO_DEPTH);
    localparam int PW  = FAW + 1;
    localparam logic [DATA_WIDTH-1:0] CMD_WRITE   = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] CMD_READ    = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP  = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU_NOP = DATA_WIDTH'(8'hDD);

    typedef enum logic [3:0] {
        S_IDLE, S_WR_ADDR, S_WR_DATA, S_RD_ADDR, S_RD_ISSUE, S_RD_WAIT,
        S_OP_A, S_OP_B, S_FUNC, S_ALU_ISSUE, S_ALU_WAIT, S_PUSH_LO, S_PUSH_HI
    } cmd_state_t;

    typedef enum logic [1:0] {TX_IDLE, TX_WAIT_HIGH, TX_WAIT_LOW} tx_state_t;

    cmd_state_t r_cmd_state, w_cmd_next;
    tx_state_t  r_tx_state, w_tx_next;

    logic [ADDRESS_WIDTH-1:0]      r_address, w_address_next;
    logic                          r_wr_en, w_wr_fire;
    logic [DATA_WIDTH-1:0]         r_wr_data;
    logic [ALU_FUNCTION_WIDTH-1:0] r_function;
    logic                          w_func_load;
    logic [2*DATA_WIDTH-1:0]       r_alu_result;
    logic                          w_result_load;
    logic                          r_cmd_error, w_err;
    logic                          w_rd_en, w_alu_en;

    logic [DATA_WIDTH-1:0] r_fifo_mem [RESPONSE_FIFO_DEPTH];
    logic [PW-1:0]         r_wr_ptr, r_rd_ptr;
    logic [PW-1:0]         w_count, w_free;
    logic                  w_full, w_empty, w_two_free;
    logic                  w_push, w_pop;
    logic [DATA_WIDTH-1:0] w_push_data;
    logic [DATA_WIDTH-1:0] r_tx_data;
    logic                  r_tx_valid;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (r_wr_ptr[FAW-1:0] == r_rd_ptr[FAW-1:0]) && (r_wr_ptr[FAW] != r_rd_ptr[FAW]);
    assign w_count    = r_wr_ptr - r_rd_ptr;
    assign w_free     = PW'(RESPONSE_FIFO_DEPTH) - w_count;
    assign w_two_free = (w_free >= PW'(2));

    always_comb begin
        w_cmd_next     = r_cmd_state;
        w_address_next = r_address;
        w_wr_fire      = 1'b0;
        w_func_load    = 1'b0;
        w_result_load  = 1'b0;
        w_err          = 1'b0;
        w_rd_en        = 1'b0;
        w_alu_en       = 1'b0;
        w_push         = 1'b0;
        w_push_data    = '0;
        case (r_cmd_state)
            S_IDLE: begin
                if (bus.rx_data_valid) begin
                    if (bus.rx_data == CMD_WRITE)        w_cmd_next = S_WR_ADDR;
                    else if (bus.rx_data == CMD_READ)    w_cmd_next = S_RD_ADDR;
                    else if (bus.rx_data == CMD_ALU_OP)  w_cmd_next = S_OP_A;
                    else if (bus.rx_data == CMD_ALU_NOP) w_cmd_next = S_FUNC;
                    else                                 w_err      = 1'b1;
                end
            end
            S_WR_ADDR: begin
                if (bus.rx_data_valid) begin
                    w_address_next = bus.rx_data[ADDRESS_WIDTH-1:0];
                    w_cmd_next     = S_WR_DATA;
                end
            end
            S_WR_DATA: begin
                if (bus.rx_data_valid) begin
                    w_wr_fire  = 1'b1;
                    w_cmd_next = S_IDLE;
                end
            end
            S_RD_ADDR: begin
                if (bus.rx_data_valid) begin
                    w_address_next = bus.rx_data[ADDRESS_WIDTH-1:0];
                    w_cmd_next     = S_RD_ISSUE;
                end
            end
            S_RD_ISSUE: begin
                w_err = bus.rx_data_valid;
                if (!w_full) begin
                    w_rd_en    = 1'b1;
                    w_cmd_next = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                w_err = bus.rx_data_valid;
                if (bus.register_file_read_data_valid) begin
                    w_push      = 1'b1;
                    w_push_data = bus.register_file_read_data;
                    w_cmd_next  = S_IDLE;
                end
            end
            S_OP_A: begin
                if (bus.rx_data_valid) begin
                    w_address_next = ADDRESS_WIDTH'(0);
                    w_wr_fire      = 1'b1;
                    w_cmd_next     = S_OP_B;
                end
            end
            S_OP_B: begin
                if (bus.rx_data_valid) begin
                    w_address_next = ADDRESS_WIDTH'(1);
                    w_wr_fire      = 1'b1;
                    w_cmd_next     = S_FUNC;
                end
            end
            S_FUNC: begin
                if (bus.rx_data_valid) begin
                    w_func_load = 1'b1;
                    w_cmd_next  = S_ALU_ISSUE;
                end
            end
            S_ALU_ISSUE: begin
                // Two free entries are reserved up front so both result bytes always fit.
                w_err = bus.rx_data_valid;
                if (w_two_free) begin
                    w_alu_en   = 1'b1;
                    w_cmd_next = S_ALU_WAIT;
                end
            end
            S_ALU_WAIT: begin
                w_err    = bus.rx_data_valid;
                w_alu_en = 1'b1;
                if (bus.ALU_result_valid) begin
                    w_result_load = 1'b1;
                    w_cmd_next    = S_PUSH_LO;
                end
            end
            S_PUSH_LO: begin
                w_err       = bus.rx_data_valid;
                w_push      = 1'b1;
                w_push_data = r_alu_result[DATA_WIDTH-1:0];
                w_cmd_next  = S_PUSH_HI;
            end
            S_PUSH_HI: begin
                w_err       = bus.rx_data_valid;
                w_push      = 1'b1;
                w_push_data = r_alu_result[2*DATA_WIDTH-1:DATA_WIDTH];
                w_cmd_next  = S_IDLE;
            end
            default: w_cmd_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_tx_next = r_tx_state;
        w_pop     = 1'b0;
        case (r_tx_state)
            TX_IDLE: begin
                if (!w_empty && !bus.transmitter_busy) begin
                    w_pop     = 1'b1;
                    w_tx_next = TX_WAIT_HIGH;
                end
            end
            TX_WAIT_HIGH: if (bus.transmitter_busy)  w_tx_next = TX_WAIT_LOW;
            TX_WAIT_LOW:  if (!bus.transmitter_busy) w_tx_next = TX_IDLE;
            default:      w_tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge reference_clk or negedge reset) begin
        if (!reset) begin
            r_cmd_state  <= S_IDLE;
            r_address    <= '0;
            r_wr_en      <= 1'b0;
            r_wr_data    <= '0;
            r_function   <= '0;
            r_alu_result <= '0;
            r_cmd_error  <= 1'b0;
        end else begin
            r_cmd_state <= w_cmd_next;
            r_address   <= w_address_next;
            r_wr_en     <= w_wr_fire;
            r_cmd_error <= w_err;
            if (w_wr_fire)     r_wr_data    <= bus.rx_data;
            if (w_func_load)   r_function   <= bus.rx_data[ALU_FUNCTION_WIDTH-1:0];
            if (w_result_load) r_alu_result <= bus.ALU_result;
        end
    end

    always_ff @(posedge reference_clk) begin
        if (w_push) r_fifo_mem[r_wr_ptr[FAW-1:0]] <= w_push_data;
    end

    always_ff @(posedge reference_clk or negedge reset) begin
        if (!reset) begin
            r_tx_state <= TX_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
        end else begin
            r_tx_state <= w_tx_next;
            r_tx_valid <= w_pop;
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + PW'(1);
                r_tx_data <= r_fifo_mem[r_rd_ptr[FAW-1:0]];
            end
        end
    end

    assign bus.register_file_address      = r_address;
    assign bus.register_file_write_enable = r_wr_en;
    assign bus.register_file_write_data   = r_wr_data;
    assign bus.register_file_read_enable  = w_rd_en;
    assign bus.ALU_enable                 = w_alu_en;
    assign bus.ALU_function               = r_function;
    assign bus.tx_data                    = r_tx_data;
    assign bus.tx_data_valid              = r_tx_valid;
    assign bus.command_error              = r_cmd_error;
endmodule

// File: tb/tb_system_command_controller.sv
// Scoreboard bench: expected writes, reads, ALU functions and transmit bytes are queued as
// frames are sent and popped by the register file, ALU and transmitter models.
module tb_system_command_controller;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    system_command_controller_if bus ();

    system_command_controller dut (
        .reference_clk (clk),
        .reset         (rst_n),
        .bus           (bus)
    );

    int total = 0;
    int bad   = 0;
    int err_cnt = 0;
    int strobe_cnt = 0;
    int wr_cnt = 0;

    logic [11:0] exp_wr [$];
    logic [3:0]  exp_rd [$];
    logic [3:0]  exp_fn [$];
    logic [7:0]  exp_tx [$];

    logic [7:0]  regs   [16];
    logic [7:0]  shadow [16];
    int          rd_delay  = 1;
    int          alu_delay = 2;
    logic [15:0] alu_next  = 16'h0000;
    logic        force_busy = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {3'b000, bus.register_file_address, bus.register_file_write_enable,
                bus.register_file_write_data, bus.register_file_read_enable, bus.ALU_enable,
                bus.ALU_function, bus.tx_data, bus.tx_data_valid, bus.command_error};
    endfunction

    task automatic send(input logic [7:0] b);
        @(posedge clk); #1;
        bus.rx_data       = b;
        bus.rx_data_valid = 1'b1;
        @(posedge clk); #1;
        bus.rx_data_valid = 1'b0;
        $display("rx byte %02h", b);
    endtask

    task automatic gap(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(posedge clk); #2;
            done = (exp_tx.size() == 0 && exp_wr.size() == 0 && exp_rd.size() == 0 &&
                    exp_fn.size() == 0 && !bus.transmitter_busy);
        end
        check({"drain_", tag}, {31'd0, done}, 32'd1);
        gap(3);
    endtask

    // Register file model: writes land on the strobe, reads answer rd_delay cycles later.
    logic       rd_pending = 1'b0;
    int         rd_left = 0;
    logic [3:0] rd_addr = 4'h0;
    always @(posedge clk) begin
        #1;
        bus.register_file_read_data_valid = 1'b0;
        if (bus.register_file_write_enable) begin
            wr_cnt++;
            strobe_cnt++;
            regs[bus.register_file_address] = bus.register_file_write_data;
            $display("write addr=%0h data=%02h", bus.register_file_address, bus.register_file_write_data);
            if (exp_wr.size() == 0) check("wr_unexpected", 32'd1, 32'd0);
            else check("wr_addr_data", {20'd0, bus.register_file_address, bus.register_file_write_data},
                       {20'd0, exp_wr.pop_front()});
        end
        if (rd_pending) begin
            if (rd_left == 0) begin
                bus.register_file_read_data_valid = 1'b1;
                bus.register_file_read_data       = regs[rd_addr];
                rd_pending = 1'b0;
            end else begin
                rd_left--;
            end
        end
        if (bus.register_file_read_enable) begin
            strobe_cnt++;
            $display("read addr=%0h", bus.register_file_address);
            if (exp_rd.size() == 0) check("rd_unexpected", 32'd1, 32'd0);
            else check("rd_addr", {28'd0, bus.register_file_address}, {28'd0, exp_rd.pop_front()});
            rd_pending = 1'b1;
            rd_addr    = bus.register_file_address;
            rd_left    = rd_delay - 1;
        end
    end

    logic alu_seen = 1'b0;
    int   alu_left = 0;
    always @(posedge clk) begin
        #1;
        bus.ALU_result_valid = 1'b0;
        if (!bus.ALU_enable) begin
            alu_seen = 1'b0;
        end else if (!alu_seen) begin
            alu_seen = 1'b1;
            strobe_cnt++;
            alu_left = alu_delay;
            $display("alu request function=%0h", bus.ALU_function);
            if (exp_fn.size() == 0) check("alu_unexpected", 32'd1, 32'd0);
            else check("alu_function", {28'd0, bus.ALU_function}, {28'd0, exp_fn.pop_front()});
        end else if (alu_left > 0) begin
            alu_left--;
            if (alu_left == 0) begin
                bus.ALU_result_valid = 1'b1;
                bus.ALU_result       = alu_next;
            end
        end
    end

    // Transmitter model: busy for three cycles after each accepted byte.
    int busy_cnt = 0;
    always @(posedge clk) begin
        #1;
        if (bus.tx_data_valid) begin
            $display("tx byte %02h", bus.tx_data);
            check("tx_after_busy_low", {31'd0, bus.transmitter_busy}, 32'd0);
            if (exp_tx.size() == 0) check("tx_unexpected", 32'd1, 32'd0);
            else check("tx_data", {24'd0, bus.tx_data}, {24'd0, exp_tx.pop_front()});
            busy_cnt = 3;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
        end
        bus.transmitter_busy = force_busy || (busy_cnt > 0);
    end

    always @(negedge clk) begin
        if (bus.command_error) err_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, s0, w0;
        bus.rx_data = '0;
        bus.rx_data_valid = 1'b0;
        bus.register_file_read_data = '0;
        bus.register_file_read_data_valid = 1'b0;
        bus.ALU_result = '0;
        bus.ALU_result_valid = 1'b0;
        bus.transmitter_busy = 1'b0;
        for (int i = 0; i < 16; i++) begin
            regs[i]   = 8'h00;
            shadow[i] = 8'h00;
        end
        rst_n = 1'b0;
        gap(3);
        check("reset_outputs", outs(), 32'd0);
        rst_n = 1'b1;
        gap(2);

        // Write then read back
        shadow[5] = 8'h3C;
        exp_wr.push_back({4'h5, 8'h3C});
        send(8'hAA); send(8'h05); send(8'h3C);
        check("wr_strobe_timing", {31'd0, bus.register_file_write_enable}, 32'd1);
        exp_rd.push_back(4'h5);
        exp_tx.push_back(shadow[5]);
        send(8'hBB); send(8'h05);
        check("rd_strobe_timing", {31'd0, bus.register_file_read_enable}, 32'd1);
        drain("write_read");

        // ALU with operands
        shadow[0] = 8'h0A;
        shadow[1] = 8'h03;
        exp_wr.push_back({4'h0, 8'h0A});
        exp_wr.push_back({4'h1, 8'h03});
        exp_fn.push_back(4'h0);
        alu_next = 16'h000D;
        exp_tx.push_back(8'h0D);
        exp_tx.push_back(8'h00);
        send(8'hCC); send(8'h0A); send(8'h03); send(8'h00);
        check("alu_en_timing", {31'd0, bus.ALU_enable}, 32'd1);
        drain("alu_operands");

        // ALU without operands
        exp_fn.push_back(4'h2);
        alu_next = 16'h1234;
        exp_tx.push_back(8'h34);
        exp_tx.push_back(8'h12);
        send(8'hDD); send(8'h02);
        check("alu_nop_en_timing", {31'd0, bus.ALU_enable}, 32'd1);
        drain("alu_no_operands");

        // Unknown command byte
        e0 = err_cnt;
        s0 = strobe_cnt;
        send(8'h7E);
        gap(4);
        check("err_unknown_cmd", err_cnt - e0, 32'd1);
        check("err_no_strobe", strobe_cnt - s0, 32'd0);
        exp_rd.push_back(4'h0);
        exp_tx.push_back(shadow[0]);
        send(8'hBB); send(8'h00);
        drain("after_error");

        // Byte arriving during RD_WAIT is dropped
        rd_delay = 6;
        e0 = err_cnt;
        exp_rd.push_back(4'h5);
        exp_tx.push_back(shadow[5]);
        send(8'hBB); send(8'h05); send(8'h55);
        drain("drop_rd_wait");
        check("err_dropped_byte", err_cnt - e0, 32'd1);
        rd_delay = 1;

        // Backpressure: three queued reads leave one slot, so the ALU must stall
        force_busy = 1'b1;
        gap(2);
        s0 = strobe_cnt;
        exp_rd.push_back(4'h1); exp_tx.push_back(shadow[1]);
        send(8'hBB); send(8'h01); gap(4);
        exp_rd.push_back(4'h2); exp_tx.push_back(shadow[2]);
        send(8'hBB); send(8'h02); gap(4);
        exp_rd.push_back(4'h5); exp_tx.push_back(shadow[5]);
        send(8'hBB); send(8'h05); gap(4);
        exp_fn.push_back(4'h0);
        alu_next = 16'hBEEF;
        exp_tx.push_back(8'hEF);
        exp_tx.push_back(8'hBE);
        send(8'hDD); send(8'h00);
        gap(10);
        check("alu_stalled", {31'd0, bus.ALU_enable}, 32'd0);
        check("stall_strobes", strobe_cnt - s0, 32'd3);
        force_busy = 1'b0;
        drain("backpressure_wrap");

        // Reset in the middle of a write frame
        send(8'hAA); send(8'h05);
        rst_n = 1'b0;
        #1;
        check("midframe_reset_outputs", outs(), 32'd0);
        gap(2);
        rst_n = 1'b1;
        gap(2);
        e0 = err_cnt;
        w0 = wr_cnt;
        send(8'h3C);
        gap(4);
        check("post_reset_no_write", wr_cnt - w0, 32'd0);
        check("post_reset_err", err_cnt - e0, 32'd1);
        exp_wr.push_back({4'h5, 8'h3C});
        send(8'hAA); send(8'h05); send(8'h3C);
        drain("fresh_write");
        check("fresh_write_count", wr_cnt - w0, 32'd1);

        check("left_tx", exp_tx.size(), 32'd0);
        check("left_wr", exp_wr.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
